// File: rtl/tube_pkg.sv
// Shared encodings and default geometry for the tube scroller.
package tube_pkg;

  typedef enum logic [1:0] {
    TILE_BODY_L = 2'd0,
    TILE_BODY_R = 2'd1,
    TILE_CAP_L  = 2'd2,
    TILE_CAP_R  = 2'd3
  } tile_sel_e;

  localparam logic [15:0] LFSR_TAPS     = 16'hB400;
  localparam logic [15:0] DEF_LFSR_SEED = 16'hACE1;

  localparam int unsigned DEF_N_TUBES  = 3;
  localparam int unsigned DEF_TUBE_W   = 32;
  localparam int unsigned DEF_SPACING  = 224;
  localparam int unsigned DEF_SCREEN_W = 640;
  localparam int unsigned DEF_GROUND_Y = 400;
  localparam int unsigned DEF_GAP_H    = 128;
  localparam int unsigned DEF_GAP_MIN  = 64;
  localparam int unsigned DEF_GAP_RST  = 160;
  localparam int unsigned DEF_CAP_H    = 16;
  localparam int unsigned DEF_SPEED    = 2;
  localparam int unsigned DEF_BIRD_X   = 160;

endpackage

// File: rtl/tube_lfsr.sv
// 16-bit Galois LFSR; shifts right, XORs in the tap mask when the bit shifted out is 1.
module tube_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1,
  parameter logic [15:0] TAPS = 16'hB400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_en,
  output logic [6:0] o_rnd
);

  logic [15:0] r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SEED;
    end else if (i_en) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end
  end

  assign o_rnd = r_state[6:0];

endmodule

// File: rtl/tube_scroller.sv
// Scrolling tube columns with respawn, per-pixel tube hit / tile addressing and score pulse.
module tube_scroller
  import tube_pkg::*;
#(
  parameter int unsigned N_TUBES   = DEF_N_TUBES,
  parameter int unsigned TUBE_W    = DEF_TUBE_W,
  parameter int unsigned SPACING   = DEF_SPACING,
  parameter int unsigned SCREEN_W  = DEF_SCREEN_W,
  parameter int unsigned GROUND_Y  = DEF_GROUND_Y,
  parameter int unsigned GAP_H     = DEF_GAP_H,
  parameter int unsigned GAP_MIN   = DEF_GAP_MIN,
  parameter int unsigned GAP_RST   = DEF_GAP_RST,
  parameter int unsigned CAP_H     = DEF_CAP_H,
  parameter int unsigned SPEED     = DEF_SPEED,
  parameter int unsigned BIRD_X    = DEF_BIRD_X,
  parameter logic [15:0] LFSR_SEED = DEF_LFSR_SEED
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_tick,
  input  logic        run,
  input  logic [10:0] px,
  input  logic [10:0] py,
  output logic        tube_hit,
  output logic [1:0]  tile_sel,
  output logic [10:0] ix,
  output logic [10:0] iy,
  output logic        score_pulse
);

  localparam logic signed [11:0] TW   = 12'(TUBE_W);
  localparam logic signed [11:0] SPD  = 12'(SPEED);
  localparam logic signed [11:0] WRAP = 12'(N_TUBES * SPACING);
  localparam logic signed [11:0] BIRD = 12'(BIRD_X);
  localparam logic [10:0] GMIN = 11'(GAP_MIN);
  localparam logic [10:0] GH   = 11'(GAP_H);
  localparam logic [10:0] CH   = 11'(CAP_H);
  localparam logic [10:0] GY   = 11'(GROUND_Y);

  logic                w_step;
  logic [6:0]          w_rnd;
  logic signed [11:0]  w_px;
  logic signed [11:0]  w_x   [N_TUBES];
  logic [10:0]         w_gap [N_TUBES];
  logic [N_TUBES-1:0]  w_in;
  logic [N_TUBES-1:0]  w_cross;

  assign w_step = frame_tick & run;
  assign w_px   = signed'({1'b0, px});

  tube_lfsr #(
    .SEED (LFSR_SEED),
    .TAPS (LFSR_TAPS)
  ) u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (frame_tick),
    .o_rnd (w_rnd)
  );

  for (genvar i = 0; i < N_TUBES; i++) begin : g_tube
    localparam logic signed [11:0] X_RST = 12'(SCREEN_W + i * SPACING);

    logic signed [11:0] r_x;
    logic [10:0]        r_gap;
    logic signed [11:0] w_nx;
    logic signed [11:0] w_next;
    logic               w_respawn;

    assign w_nx       = r_x - SPD;
    assign w_respawn  = (w_nx <= -TW);
    assign w_next     = w_respawn ? (w_nx + WRAP) : w_nx;
    // A respawned tube lands far right, so only a plain step can cross the bird.
    assign w_cross[i] = (r_x + TW > BIRD) && (w_next + TW <= BIRD);
    assign w_in[i]    = (w_px >= r_x) && (w_px < r_x + TW);
    assign w_x[i]     = r_x;
    assign w_gap[i]   = r_gap;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x   <= X_RST;
        r_gap <= 11'(GAP_RST);
      end else if (w_step) begin
        r_x <= w_next;
        if (w_respawn) r_gap <= GMIN + {4'b0000, w_rnd};
      end
    end
  end

  logic        w_any;
  logic [4:0]  w_sx;
  logic [10:0] w_sg;

  // Lowest-index tube wins when columns overlap.
  always_comb begin
    w_any = 1'b0;
    w_sx  = '0;
    w_sg  = '0;
    for (int unsigned k = 0; k < N_TUBES; k++) begin
      if (w_in[k] && !w_any) begin
        w_any = 1'b1;
        w_sx  = w_x[k][4:0];
        w_sg  = w_gap[k];
      end
    end
  end

  logic [4:0]  w_dx;
  logic [10:0] w_up_start;
  logic [10:0] w_lo_start;
  logic        w_upper;
  logic        w_lower;
  logic        w_cap;
  logic        w_hit;
  logic [3:0]  w_iy;
  tile_sel_e   w_sel;

  always_comb begin
    w_dx       = px[4:0] - w_sx;
    w_up_start = w_sg - CH;
    w_lo_start = w_sg + GH;
    w_upper    = (py < w_sg);
    w_lower    = (py >= w_lo_start) && (py < GY);
    w_cap      = (w_upper && (py >= w_up_start)) || (w_lower && (py < w_lo_start + CH));
    w_hit      = w_any && (w_upper || w_lower);
    if (!w_cap)       w_iy = py[3:0];
    else if (w_upper) w_iy = py[3:0] - w_up_start[3:0];
    else              w_iy = py[3:0] - w_lo_start[3:0];
    if (w_cap) w_sel = w_dx[4] ? TILE_CAP_R  : TILE_CAP_L;
    else       w_sel = w_dx[4] ? TILE_BODY_R : TILE_BODY_L;
  end

  logic        r_hit;
  tile_sel_e   r_sel;
  logic [10:0] r_ix;
  logic [10:0] r_iy;
  logic        r_score;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit   <= 1'b0;
      r_sel   <= TILE_BODY_L;
      r_ix    <= '0;
      r_iy    <= '0;
      r_score <= 1'b0;
    end else begin
      r_hit   <= w_hit;
      r_sel   <= w_hit ? w_sel : TILE_BODY_L;
      r_ix    <= w_hit ? {7'b0, w_dx[3:0]} : '0;
      r_iy    <= w_hit ? {7'b0, w_iy} : '0;
      r_score <= w_step && (|w_cross);
    end
  end

  assign tube_hit    = r_hit;
  assign tile_sel    = r_sel;
  assign ix          = r_ix;
  assign iy          = r_iy;
  assign score_pulse = r_score;

endmodule

// File: tb/tb_tube_scroller.sv
// Randomized bench for tube_scroller against a behavioural model of tube motion and pixel classification.
module tb_tube_scroller;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        frame_tick = 1'b0;
  logic        run = 1'b0;
  logic [10:0] px = '0;
  logic [10:0] py = '0;
  logic        tube_hit;
  logic [1:0]  tile_sel;
  logic [10:0] ix;
  logic [10:0] iy;
  logic        score_pulse;

  tube_scroller dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_tick  (frame_tick),
    .run         (run),
    .px          (px),
    .py          (py),
    .tube_hit    (tube_hit),
    .tile_sel    (tile_sel),
    .ix          (ix),
    .iy          (iy),
    .score_pulse (score_pulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model state: plain integer tube positions, gaps and the LFSR value.
  int          m_x   [3];
  int          m_gap [3];
  logic [15:0] m_lfsr;
  int e_hit, e_sel, e_ix, e_iy, e_score;

  always @(posedge clk or negedge rst_n) begin
    int t, dx, g, nx, nw, ipx, ipy;
    bit cap, hit;
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_x[i]   = 640 + i * 224;
        m_gap[i] = 160;
      end
      m_lfsr = 16'hACE1;
      e_hit = 0; e_sel = 0; e_ix = 0; e_iy = 0; e_score = 0;
    end else begin
      ipx = int'(px);
      ipy = int'(py);
      t = -1;
      for (int i = 0; i < 3; i++)
        if (t < 0 && ipx >= m_x[i] && ipx < m_x[i] + 32) t = i;
      hit = 0; cap = 0;
      e_hit = 0; e_sel = 0; e_ix = 0; e_iy = 0;
      if (t >= 0) begin
        dx = ipx - m_x[t];
        g  = m_gap[t];
        if (ipy < g) begin
          hit = 1;
          cap = (ipy >= g - 16);
          e_iy = cap ? ipy - (g - 16) : ipy % 16;
        end else if (ipy >= g + 128 && ipy < 400) begin
          hit = 1;
          cap = (ipy < g + 144);
          e_iy = cap ? ipy - (g + 128) : ipy % 16;
        end
        if (hit) begin
          e_hit = 1;
          e_ix  = dx % 16;
          e_sel = (cap ? 2 : 0) + ((dx / 16) % 2);
        end else begin
          e_iy = 0;
        end
      end
      e_score = 0;
      if (frame_tick) begin
        if (run) begin
          for (int i = 0; i < 3; i++) begin
            nx = m_x[i] - 2;
            nw = (nx <= -32) ? nx + 672 : nx;
            if (m_x[i] + 32 > 160 && nw + 32 <= 160) e_score = 1;
            if (nx <= -32) m_gap[i] = 64 + int'(m_lfsr[6:0]);
            m_x[i] = nw;
          end
        end
        m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("tube_hit", int'(tube_hit), e_hit);
      chk("tile_sel", int'(tile_sel), e_sel);
      chk("ix", int'(ix), e_ix);
      chk("iy", int'(iy), e_iy);
      chk("score_pulse", int'(score_pulse), e_score);
    end
  end

  task automatic frame(input bit r);
    @(negedge clk);
    frame_tick = 1'b1;
    run = r;
    @(negedge clk);
    frame_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y);
    @(negedge clk);
    px = 11'(x);
    py = 11'(y);
    @(negedge clk);
  endtask

  task automatic chk_outs_zero(input string tag);
    chk({tag, "_hit"}, int'(tube_hit), 0);
    chk({tag, "_sel"}, int'(tile_sel), 0);
    chk({tag, "_ix"}, int'(ix), 0);
    chk({tag, "_iy"}, int'(iy), 0);
    chk({tag, "_score"}, int'(score_pulse), 0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_x0"}, int'(dut.g_tube[0].r_x), 640);
    chk({tag, "_x1"}, int'(dut.g_tube[1].r_x), 864);
    chk({tag, "_x2"}, int'(dut.g_tube[2].r_x), 1088);
    chk({tag, "_gap0"}, int'(dut.g_tube[0].r_gap), 160);
    chk({tag, "_gap2"}, int'(dut.g_tube[2].r_gap), 160);
    chk({tag, "_lfsr"}, int'(dut.u_lfsr.r_state), 16'hACE1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int g;
    #1 rst_n = 1'b0;
    #20;
    chk_outs_zero("rst");
    chk_reset_state("rst");
    @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;

    frame(1'b0);
    chk("norun_x0", int'(dut.g_tube[0].r_x), 640);
    chk("norun_lfsr", int'(dut.u_lfsr.r_state), 16'hE270);

    for (int k = 1; k <= 16; k++) frame(1'b1);
    chk("scroll16_x0", int'(dut.g_tube[0].r_x), 608);

    pix(610, 40);
    chk("p1_hit", int'(tube_hit), 1);
    chk("p1_sel", int'(tile_sel), 0);
    chk("p1_ix", int'(ix), 2);
    chk("p1_iy", int'(iy), 8);
    pix(625, 150);
    chk("p2_sel", int'(tile_sel), 3);
    chk("p2_ix", int'(ix), 1);
    chk("p2_iy", int'(iy), 6);
    pix(610, 288);
    chk("p3_hit", int'(tube_hit), 1);
    chk("p3_sel", int'(tile_sel), 2);
    chk("p3_iy", int'(iy), 0);
    pix(610, 200);
    chk("p4_hit", int'(tube_hit), 0);

    for (int k = 17; k <= 255; k++) frame(1'b1);
    chk("tick255_score", int'(score_pulse), 0);
    frame(1'b1);
    chk("tick256_score", int'(score_pulse), 1);
    chk("tick256_x0", int'(dut.g_tube[0].r_x), 128);
    @(negedge clk);
    chk("tick256_width", int'(score_pulse), 0);

    for (int k = 257; k <= 336; k++) frame(1'b1);
    chk("respawn_x0", int'(dut.g_tube[0].r_x), 640);
    g = int'(dut.g_tube[0].r_gap);
    chk("respawn_gap0", g, m_gap[0]);
    chk("respawn_gap_range", int'(g >= 64 && g <= 191), 1);

    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      px = 11'($urandom_range(0, 1150));
      py = 11'($urandom_range(0, 450));
      frame_tick = ($urandom_range(0, 3) == 0);
      run = ($urandom_range(0, 7) != 0);
    end
    @(negedge clk);
    frame_tick = 1'b0;

    px = 11'(m_x[0] + 5);
    py = 11'(10);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_outs_zero("async");
    chk_reset_state("async");
    #2 rst_n = 1'b1;

    for (int k = 0; k < 20; k++) frame(1'b1);
    for (int c = 0; c < 200; c++) pix($urandom_range(0, 800), $urandom_range(0, 420));

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
